// File: rtl/vga_timing_gen.sv
// Free-running raster timing generator (1024x768 @ 70 Hz on a 75 MHz pixel clock).
// Optional build macro VTG_BLANK_COORD_EN forces the coordinates to 12'hFFF during blanking.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 1024,
    parameter int H_FP       = 24,
    parameter int H_SYNC     = 136,
    parameter int H_BP       = 144,
    parameter int V_ACTIVE   = 768,
    parameter int V_FP       = 3,
    parameter int V_SYNC     = 6,
    parameter int V_BP       = 29,
    parameter bit H_POL      = 1'b0,
    parameter bit V_POL      = 1'b0,
    parameter int SYNC_DELAY = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [11:0] pixel_column,
    output logic [11:0] pixel_row,
    output logic        video_on,
    output logic        horiz_sync,
    output logic        vert_sync,
    output logic        frame_tick
);

    localparam logic [11:0] H_LAST    = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] V_LAST    = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [11:0] H_VIS     = 12'(H_ACTIVE);
    localparam logic [11:0] V_VIS     = 12'(V_ACTIVE);
    localparam logic [11:0] HS_START  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] VS_START  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END    = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [11:0]         h_cnt;
    logic [11:0]         v_cnt;
    logic                vid_raw;
    logic                hs_raw;
    logic                vs_raw;
    // Index 0 is the stage 1 register; the remaining entries form the delay line.
    logic [SYNC_DELAY:0] hs_pipe;
    logic [SYNC_DELAY:0] vs_pipe;

    always_comb begin
        vid_raw = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs_raw  = (h_cnt >= HS_START) && (h_cnt <= HS_END);
        vs_raw  = (v_cnt >= VS_START) && (v_cnt <= VS_END);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_column <= '0;
            pixel_row    <= '0;
            video_on     <= 1'b0;
            frame_tick   <= 1'b0;
            hs_pipe      <= {(SYNC_DELAY + 1){~H_POL}};
            vs_pipe      <= {(SYNC_DELAY + 1){~V_POL}};
        end else begin
`ifdef VTG_BLANK_COORD_EN
            pixel_column <= vid_raw ? h_cnt : 12'hFFF;
            pixel_row    <= vid_raw ? v_cnt : 12'hFFF;
`else
            pixel_column <= h_cnt;
            pixel_row    <= v_cnt;
`endif
            video_on     <= vid_raw;
            frame_tick   <= (h_cnt == 12'd0) && (v_cnt == V_VIS);
            hs_pipe[0]   <= hs_raw ? H_POL : ~H_POL;
            vs_pipe[0]   <= vs_raw ? V_POL : ~V_POL;
            for (int i = 1; i <= SYNC_DELAY; i++) begin
                hs_pipe[i] <= hs_pipe[i-1];
                vs_pipe[i] <= vs_pipe[i-1];
            end
        end
    end

    assign horiz_sync = hs_pipe[SYNC_DELAY];
    assign vert_sync  = vs_pipe[SYNC_DELAY];

endmodule
